// File: rtl/key_pkg.sv
// Shared definitions for the key event decoder slice.
//   key_state_t  : gesture FSM state encoding
//   *_DEF        : default timer counts for a 50 MHz system clock
//   is_held      : states in which the key is physically down
//   is_timed     : states in which the event timer runs
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_LONG   = 3'd4
  } key_state_t;

  localparam int unsigned LONG_CNT_DEF    = 50_000_000;  // 1 s hold
  localparam int unsigned DBL_GAP_CNT_DEF = 15_000_000;  // 300 ms gap
  localparam int unsigned REPEAT_CNT_DEF  = 10_000_000;  // 200 ms repeat
  localparam int          CNT_W_DEF       = 32;

  function automatic logic is_held(key_state_t s);
    return (s == ST_PRESS1) || (s == ST_PRESS2) || (s == ST_LONG);
  endfunction

  function automatic logic is_timed(key_state_t s);
    return (s == ST_PRESS1) || (s == ST_WAIT2) || (s == ST_LONG);
  endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Event stream in / gesture pulses out between the key debouncer side
// (master) and the gesture decoder (slave).
//   key_flag, key_value      : debouncer strobe + debounced level (0 = pressed)
//   short_press, double_press,
//   long_press, repeat_press : 1-cycle gesture pulses
//   key_held                 : level, key currently considered down
interface key_event_decoder_if;

  logic key_flag;
  logic key_value;
  logic short_press;
  logic double_press;
  logic long_press;
  logic repeat_press;
  logic key_held;

  modport master (
    output key_flag,
    output key_value,
    input  short_press,
    input  double_press,
    input  long_press,
    input  repeat_press,
    input  key_held
  );

  modport slave (
    input  key_flag,
    input  key_value,
    output short_press,
    output double_press,
    output long_press,
    output repeat_press,
    output key_held
  );

endinterface

// File: rtl/evt_timer.sv
// Clear/enable saturating event counter with a terminal compare.
//   clk, srst : clock, synchronous active-high reset
//   clr       : force count to zero (has priority over en)
//   en        : count up by one this cycle
//   limit     : run-time period N; terminal flags the last cycle (cnt == N-1)
//   terminal  : combinational compare of the registered count
module evt_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en && (cnt_reg != '1)) begin
      // Saturate instead of wrapping so a stalled state can never alias
      // back onto a terminal count.
      cnt_next = cnt_reg + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign terminal = (cnt_reg == (limit - ONE));

endmodule

// File: rtl/key_event_decoder.sv
// Classifies the debounced key event stream into gestures: short press,
// double press, long press and auto-repeat while held.
//   sys_clk : system clock
//   sys_rst : synchronous reset, active-high
//   key_if  : slave side of key_event_decoder_if (events in, pulses out)
// All outputs are registered; a gesture pulse appears the cycle after the
// cycle in which it was decided.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT    = LONG_CNT_DEF,
  parameter int unsigned DBL_GAP_CNT = DBL_GAP_CNT_DEF,
  parameter int unsigned REPEAT_CNT  = REPEAT_CNT_DEF,
  parameter int          CNT_W       = CNT_W_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  key_event_decoder_if.slave key_if
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_GAP_CNT);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CNT);

  // Pulse vector bit positions
  localparam int P_SHORT  = 0;
  localparam int P_DOUBLE = 1;
  localparam int P_LONG   = 2;
  localparam int P_REPEAT = 3;

  key_state_t       state_reg;
  key_state_t       state_next;
  logic [3:0]       pulse_reg;
  logic [3:0]       pulse_next;
  logic             key_held_reg;

  logic             press_evt;
  logic             release_evt;
  logic             timer_clr;
  logic             timer_en;
  logic             timer_term;
  logic             repeat_clr;
  logic [CNT_W-1:0] timer_limit;

  // key_value only carries meaning on a flag cycle.
  assign press_evt   = key_if.key_flag & ~key_if.key_value;
  assign release_evt = key_if.key_flag &  key_if.key_value;

  always_comb begin
    timer_limit = '0;
    unique case (state_reg)
      ST_PRESS1: timer_limit = LONG_LIM;
      ST_WAIT2:  timer_limit = DBL_LIM;
      ST_LONG:   timer_limit = REP_LIM;
      default:   timer_limit = '0;
    endcase
  end

  // Key events are tested before the timer terminal in every state, so an
  // event landing on the terminal cycle suppresses the timed gesture.
  always_comb begin
    state_next = state_reg;
    pulse_next = '0;
    repeat_clr = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (press_evt) state_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (release_evt) begin
          state_next = ST_WAIT2;
        end else if (timer_term) begin
          state_next         = ST_LONG;
          pulse_next[P_LONG] = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (press_evt) begin
          state_next = ST_PRESS2;
        end else if (timer_term) begin
          state_next          = ST_IDLE;
          pulse_next[P_SHORT] = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (release_evt) begin
          state_next           = ST_IDLE;
          pulse_next[P_DOUBLE] = 1'b1;
        end
      end
      ST_LONG: begin
        if (release_evt) begin
          state_next = ST_IDLE;
        end else if (timer_term) begin
          // Stay in LONG and restart the period.
          pulse_next[P_REPEAT] = 1'b1;
          repeat_clr           = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign timer_clr = (state_next != state_reg) | repeat_clr;
  assign timer_en  = is_timed(state_reg);

  evt_timer #(
    .CNT_W (CNT_W)
  ) u_evt_timer (
    .clk      (sys_clk),
    .srst     (sys_rst),
    .clr      (timer_clr),
    .en       (timer_en),
    .limit    (timer_limit),
    .terminal (timer_term)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= ST_IDLE;
      pulse_reg    <= '0;
      key_held_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pulse_reg    <= pulse_next;
      key_held_reg <= is_held(state_next);
    end
  end

  assign key_if.short_press  = pulse_reg[P_SHORT];
  assign key_if.double_press = pulse_reg[P_DOUBLE];
  assign key_if.long_press   = pulse_reg[P_LONG];
  assign key_if.repeat_press = pulse_reg[P_REPEAT];
  assign key_if.key_held     = key_held_reg;

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder with shortened counts
// (LONG_CNT=20, DBL_GAP_CNT=10, REPEAT_CNT=5). Expected gesture pulses are
// queued with their absolute cycle when stimulus is driven; a negedge
// monitor pops and compares them as the DUT produces pulses.
module tb_key_event_decoder;

  localparam logic [3:0] M_SHORT = 4'b0001;
  localparam logic [3:0] M_DBL   = 4'b0010;
  localparam logic [3:0] M_LONG  = 4'b0100;
  localparam logic [3:0] M_REP   = 4'b1000;

  logic sys_clk = 1'b0;
  logic sys_rst;

  key_event_decoder_if key_if();

  key_event_decoder #(
    .LONG_CNT    (20),
    .DBL_GAP_CNT (10),
    .REPEAT_CNT  (5),
    .CNT_W       (8)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key_if  (key_if)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int  pass_cnt  = 0;
  int  check_cnt = 0;
  bit  mon_en    = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb[$];
  logic [3:0] obs_mask;

  // Scoreboard monitor: any pulse must match the head of the queue exactly
  // (cycle and kind); a head whose cycle passed unseen is a missed pulse.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      obs_mask = {key_if.repeat_press, key_if.long_press,
                  key_if.double_press, key_if.short_press};
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check_cnt++;
        $display("FAIL missed_pulse cycle %0d got none required mask %b",
                 sb[0].cyc, sb[0].mask);
        void'(sb.pop_front());
      end
      if (obs_mask != 4'b0000) begin
        check_cnt++;
        if (sb.size() > 0 && sb[0].cyc == cyc && sb[0].mask === obs_mask) begin
          pass_cnt++;
          $display("pulse ok cycle %0d mask %b", cyc, obs_mask);
          void'(sb.pop_front());
        end else if (sb.size() > 0) begin
          $display("FAIL pulse cycle %0d got mask %b required mask %b at cycle %0d",
                   cyc, obs_mask, sb[0].mask, sb[0].cyc);
        end else begin
          $display("FAIL pulse cycle %0d got mask %b required none", cyc, obs_mask);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_pulse(input int unsigned at, input logic [3:0] m);
    exp_t e;
    e.cyc  = at;
    e.mask = m;
    sb.push_back(e);
  endtask

  // One cycle of stimulus; returns 1 time unit after the sampling edge.
  task automatic drive(input bit flag, input bit val);
    key_if.key_flag  = flag;
    key_if.key_value = val;
    @(posedge sys_clk);
    #1;
    key_if.key_flag = 1'b0;
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) drive(1'b0, key_if.key_value);
  endtask

  task automatic test_reset();
    sys_rst          = 1'b1;
    key_if.key_flag  = 1'b0;
    key_if.key_value = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_cnt++;
    if ({key_if.short_press, key_if.double_press, key_if.long_press,
         key_if.repeat_press, key_if.key_held} !== 5'b00000) begin
      $display("FAIL reset_outputs got %b required 00000",
               {key_if.short_press, key_if.double_press, key_if.long_press,
                key_if.repeat_press, key_if.key_held});
    end else begin
      pass_cnt++;
      $display("reset outputs ok");
    end
    sys_rst = 1'b0;
    mon_en  = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    check_cnt++;
    if (key_if.key_held !== 1'b0) begin
      $display("FAIL idle_held got %b required 0", key_if.key_held);
    end else begin
      pass_cnt++;
      $display("idle after reset ok");
    end
  endtask

  task automatic test_short();
    int unsigned base;
    drive(1'b0, 1'b1);
    base = cyc;
    expect_pulse(base + 16, M_SHORT);
    drive(1'b1, 1'b0);
    check_cnt++;
    if (key_if.key_held !== 1'b1) begin
      $display("FAIL short_held got %b required 1", key_if.key_held);
    end else begin
      pass_cnt++;
    end
    wait_until(base + 5);
    drive(1'b1, 1'b1);
    wait_until(base + 25);
    check_cnt++;
    if (sb.size() !== 0) begin
      $display("FAIL short_pending got %0d required 0", sb.size());
    end else begin
      pass_cnt++;
      $display("short scenario done");
    end
  endtask

  task automatic test_double();
    int unsigned base;
    drive(1'b0, 1'b1);
    base = cyc;
    expect_pulse(base + 15, M_DBL);
    drive(1'b1, 1'b0);
    wait_until(base + 5);
    drive(1'b1, 1'b1);
    wait_until(base + 10);
    drive(1'b1, 1'b0);
    check_cnt++;
    if (key_if.key_held !== 1'b1) begin
      $display("FAIL double_held got %b required 1", key_if.key_held);
    end else begin
      pass_cnt++;
    end
    wait_until(base + 14);
    drive(1'b1, 1'b1);
    wait_until(base + 32);
    check_cnt++;
    if (sb.size() !== 0 || key_if.key_held !== 1'b0) begin
      $display("FAIL double_end got pending %0d held %b required 0 0",
               sb.size(), key_if.key_held);
    end else begin
      pass_cnt++;
      $display("double scenario done");
    end
  endtask

  task automatic test_long_repeat();
    int unsigned base;
    drive(1'b0, 1'b1);
    base = cyc;
    expect_pulse(base + 21, M_LONG);
    expect_pulse(base + 26, M_REP);
    expect_pulse(base + 31, M_REP);
    expect_pulse(base + 36, M_REP);
    drive(1'b1, 1'b0);
    check_cnt++;
    if (key_if.key_held !== 1'b1) begin
      $display("FAIL long_held_t1 got %b required 1", key_if.key_held);
    end else begin
      pass_cnt++;
    end
    wait_until(base + 40);
    check_cnt++;
    if (key_if.key_held !== 1'b1) begin
      $display("FAIL long_held_t40 got %b required 1", key_if.key_held);
    end else begin
      pass_cnt++;
    end
    // Release lands on a repeat terminal: release wins, no fourth repeat.
    drive(1'b1, 1'b1);
    check_cnt++;
    if (key_if.key_held !== 1'b0) begin
      $display("FAIL long_held_t41 got %b required 0", key_if.key_held);
    end else begin
      pass_cnt++;
    end
    wait_until(base + 55);
    check_cnt++;
    if (sb.size() !== 0) begin
      $display("FAIL long_pending got %0d required 0", sb.size());
    end else begin
      pass_cnt++;
      $display("long/repeat scenario done");
    end
  endtask

  task automatic test_boundary();
    int unsigned base;
    // Release on the PRESS1 terminal cycle: no long, short later.
    drive(1'b0, 1'b1);
    base = cyc;
    expect_pulse(base + 31, M_SHORT);
    drive(1'b1, 1'b0);
    wait_until(base + 20);
    drive(1'b1, 1'b1);
    wait_until(base + 40);
    // Release one cycle later: long fires, no short.
    base = cyc;
    expect_pulse(base + 21, M_LONG);
    drive(1'b1, 1'b0);
    wait_until(base + 21);
    drive(1'b1, 1'b1);
    check_cnt++;
    if (key_if.key_held !== 1'b0) begin
      $display("FAIL boundary_held got %b required 0", key_if.key_held);
    end else begin
      pass_cnt++;
    end
    wait_until(base + 40);
    check_cnt++;
    if (sb.size() !== 0) begin
      $display("FAIL boundary_pending got %0d required 0", sb.size());
    end else begin
      pass_cnt++;
      $display("boundary scenario done");
    end
  endtask

  task automatic test_reset_mid_long();
    int unsigned base;
    drive(1'b0, 1'b1);
    base = cyc;
    expect_pulse(base + 21, M_LONG);
    drive(1'b1, 1'b0);
    wait_until(base + 23);
    sys_rst = 1'b1;
    drive(1'b0, 1'b0);
    sys_rst = 1'b0;
    check_cnt++;
    if ({key_if.short_press, key_if.double_press, key_if.long_press,
         key_if.repeat_press, key_if.key_held} !== 5'b00000) begin
      $display("FAIL midreset_outputs got %b required 00000",
               {key_if.short_press, key_if.double_press, key_if.long_press,
                key_if.repeat_press, key_if.key_held});
    end else begin
      pass_cnt++;
    end
    // Stale release after reset must be ignored.
    drive(1'b1, 1'b1);
    wait_until(base + 45);
    check_cnt++;
    if (key_if.key_held !== 1'b0) begin
      $display("FAIL midreset_held got %b required 0", key_if.key_held);
    end else begin
      pass_cnt++;
    end
    base = cyc;
    expect_pulse(base + 16, M_SHORT);
    drive(1'b1, 1'b0);
    wait_until(base + 5);
    drive(1'b1, 1'b1);
    wait_until(base + 25);
    check_cnt++;
    if (sb.size() !== 0) begin
      $display("FAIL midreset_pending got %0d required 0", sb.size());
    end else begin
      pass_cnt++;
      $display("reset mid-long scenario done");
    end
  endtask

  task automatic test_redundant();
    int unsigned base;
    // Short click with redundant flags and flagless value toggles.
    drive(1'b0, 1'b1);
    base = cyc;
    expect_pulse(base + 16, M_SHORT);
    drive(1'b1, 1'b0);   // t=0 press
    drive(1'b0, 1'b0);   // t=1
    drive(1'b1, 1'b0);   // t=2 redundant press
    drive(1'b1, 1'b0);   // t=3 redundant press
    drive(1'b0, 1'b1);   // t=4 toggle without flag
    drive(1'b1, 1'b1);   // t=5 release
    drive(1'b0, 1'b0);   // t=6 toggle without flag
    drive(1'b1, 1'b1);   // t=7 redundant release
    drive(1'b0, 1'b0);   // t=8 toggle without flag
    drive(1'b0, 1'b1);   // t=9
    wait_until(base + 25);
    // Long hold with noise in PRESS1 and LONG.
    base = cyc;
    expect_pulse(base + 21, M_LONG);
    expect_pulse(base + 26, M_REP);
    drive(1'b1, 1'b0);
    wait_until(base + 3);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    wait_until(base + 10);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    wait_until(base + 23);
    drive(1'b1, 1'b0);
    wait_until(base + 28);
    drive(1'b1, 1'b1);
    wait_until(base + 40);
    check_cnt++;
    if (sb.size() !== 0 || key_if.key_held !== 1'b0) begin
      $display("FAIL redundant_end got pending %0d held %b required 0 0",
               sb.size(), key_if.key_held);
    end else begin
      pass_cnt++;
      $display("redundant events scenario done");
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_boundary();
    test_reset_mid_long();
    test_redundant();
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
